dcache_wb: RTL

Parametrised direct-mapped data cache with write-back policy, byte/word access and a built-in miss controller. It sits between the core's load/store stage and the single-ported main memory. It answers hits in the request cycle, and on a miss it writes back a dirty victim line and refills the line from memory one word at a time. It replaces the fixed 4×4-word, write-through-less cache array and takes over the miss sequencing previously left to the core.

---
 rtl/dcache_wb.sv | 115 +++++++++++
 1 files changed

// File: rtl/dcache_wb.sv
// dcache_wb: direct-mapped write-back data cache with byte/word access and a
// word-serial miss controller (dirty write-back, then refill).
module dcache_wb #(
  parameter int INDEX_W  = 2,
  parameter int OFFSET_W = 2,
  parameter int ADDR_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_byte,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W - 2;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
  state_t state;
  logic [31:0] data [LINES][WORDS];
  logic [TAG_W-1:0] tags [LINES];
  logic [LINES-1:0] valid, dirty;
  logic [OFFSET_W-1:0] cnt;
  logic [TAG_W-1:0] m_tag;
  logic [INDEX_W-1:0] m_idx;
  logic [TAG_W-1:0] a_tag;
  logic [INDEX_W-1:0] a_idx;
  logic [OFFSET_W-1:0] a_word;
  logic [1:0] lane;
  logic [31:0] rword;
  logic [7:0] rbyte;
  logic hit, last;
  always_comb begin
    a_tag  = cpu_addr[ADDR_W-1 -: TAG_W];
    a_idx  = cpu_addr[OFFSET_W+2 +: INDEX_W];
    a_word = cpu_addr[2 +: OFFSET_W];
    lane   = cpu_addr[1:0];
    rword  = data[a_idx][a_word];
    rbyte  = rword[{lane, 3'b000} +: 8];
    hit    = cpu_req && state == IDLE && valid[a_idx] && tags[a_idx] == a_tag;
    last   = &cnt;
    cpu_ready = hit;
    cpu_rdata = (hit && !cpu_we) ? (cpu_byte ? {24'd0, rbyte} : rword) : 32'd0;
    mem_req   = state != IDLE;
    mem_we    = state == WRITEBACK;
    mem_addr  = state == WRITEBACK ? {tags[m_idx], m_idx, cnt, 2'b00} :
                state == REFILL    ? {m_tag, m_idx, cnt, 2'b00} : '0;
    mem_wdata = state == WRITEBACK ? data[m_idx][cnt] : 32'd0;
  end
  // The miss address is latched so the transfer finishes even if the core drops its request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      valid <= '0;
      dirty <= '0;
      m_tag <= '0;
      m_idx <= '0;
      for (int l = 0; l < LINES; l++) begin
        tags[l] <= '0;
        for (int w = 0; w < WORDS; w++) data[l][w] <= 32'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (hit && cpu_we) begin
            if (cpu_byte) data[a_idx][a_word][{lane, 3'b000} +: 8] <= cpu_wdata[7:0];
            else data[a_idx][a_word] <= cpu_wdata;
            dirty[a_idx] <= 1'b1;
          end else if (cpu_req && !hit) begin
            m_tag <= a_tag;
            m_idx <= a_idx;
            if (valid[a_idx] && dirty[a_idx]) state <= WRITEBACK;
            else begin
              state        <= REFILL;
              valid[a_idx] <= 1'b0;
              dirty[a_idx] <= 1'b0;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              state        <= REFILL;
              valid[m_idx] <= 1'b0;
              dirty[m_idx] <= 1'b0;
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            data[m_idx][cnt] <= mem_rdata;
            cnt <= cnt + 1'b1;
            if (last) begin
              tags[m_idx]  <= m_tag;
              valid[m_idx] <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
